// File: rtl/ram_pkg.sv
// Shared constants for the byte-enable single-port RAM: default geometry and
// the clear-sequencer state encoding.
package ram_pkg;
   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 64;
   localparam int ADDR_W_DEF = 7;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_CLEAR = 1'b1;
endpackage

// File: rtl/ram_clear_fsm.sv
// Clear sequencer: walks a pointer over every word once after reset or a clr
// request, holding busy high for exactly DEPTH cycles.
module ram_clear_fsm
   import ram_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   output logic             busy,
   output logic [IDX_W-1:0] ptr
);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

   logic [0:0] state;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_CLEAR;
         ptr   <= '0;
      end else begin
         case (state)
            S_CLEAR: begin
               if (ptr == LAST) begin
                  state <= S_IDLE;
                  ptr   <= '0;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            default: begin
               if (clr) begin
                  state <= S_CLEAR;
                  ptr   <= '0;
               end
            end
         endcase
      end
   end

   assign busy = (state == S_CLEAR);
endmodule

// File: rtl/ram_sp_be_gen.sv
// Single-port RAM with per-byte write enables, registered read (latency 1),
// out-of-range error pulse and a multi-cycle clear walk.
module ram_sp_be_gen
   import ram_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req,
   input  logic                we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W/8-1:0] be,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                clr,
   output logic [DATA_W-1:0]   rdata,
   output logic                rvalid,
   output logic                err,
   output logic                busy
);
   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = $clog2(DEPTH);

   logic [NB-1:0][7:0] mem [DEPTH];
   logic [NB-1:0][7:0] wbytes;
   logic [IDX_W-1:0]   clr_ptr;
   logic [IDX_W-1:0]   idx;
   logic               in_range;
   logic               acc;

   ram_clear_fsm #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_clear (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .busy  (busy),
      .ptr   (clr_ptr)
   );

   assign wbytes   = wdata;
   assign idx      = addr[IDX_W-1:0];
   assign in_range = 32'(addr) < DEPTH;
   // clr wins over a same-cycle request; nothing is accepted while clearing
   assign acc      = req && !busy && !clr;

   always_ff @(posedge clk) begin
      if (reset) begin
         if (busy) begin
            mem[clr_ptr] <= '0;
         end else if (acc && we && in_range) begin
            for (int k = 0; k < NB; k++) begin
               if (be[k]) mem[idx][k] <= wbytes[k];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rdata  <= '0;
         rvalid <= 1'b0;
         err    <= 1'b0;
      end else begin
         rvalid <= 1'b0;
         err    <= 1'b0;
         if (acc) begin
            if (!in_range) begin
               err <= 1'b1;
            end else if (!we) begin
               rdata  <= mem[idx];
               rvalid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_ram_sp_be_gen.sv
// Directed bench for ram_sp_be_gen (32-bit words, 64 entries).
module tb_ram_sp_be_gen;
   logic        clk;
   logic        reset;
   logic        req;
   logic        we;
   logic [6:0]  addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        clr;
   logic [31:0] rdata;
   logic        rvalid;
   logic        err;
   logic        busy;

   int pass_cnt = 0;
   int total    = 0;

   ram_sp_be_gen #(.DATA_W(32), .DEPTH(64), .ADDR_W(7)) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .we     (we),
      .addr   (addr),
      .be     (be),
      .wdata  (wdata),
      .clr    (clr),
      .rdata  (rdata),
      .rvalid (rvalid),
      .err    (err),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
      $fatal(1);
   end

   task automatic issue(input logic w, input logic [6:0] a, input logic [3:0] b, input logic [31:0] d);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; be = b; wdata = d;
   endtask

   task automatic count_busy(output int cnt);
      cnt = 0;
      while (busy && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
   endtask

   task automatic test_reset();
      int cnt;
      int addrs[3] = '{0, 31, 63};
      reset = 1'b0; req = 0; we = 0; addr = 0; be = 0; wdata = 0; clr = 0;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b required 1", busy); else pass_cnt++;
      total++; if (rvalid !== 1'b0 || err !== 1'b0) $display("FAIL reset_pulses: got rvalid=%b err=%b required 0 0", rvalid, err); else pass_cnt++;
      total++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h required 00000000", rdata); else pass_cnt++;
      reset = 1'b1;
      count_busy(cnt);
      total++; if (cnt !== 64) $display("FAIL reset_busy_len: got %0d required 64", cnt); else pass_cnt++;
      foreach (addrs[i]) begin
         issue(1'b0, 7'(addrs[i]), 4'h0, 32'h0);
         @(negedge clk); req = 1'b0;
         total++; if (rvalid !== 1'b1 || rdata !== 32'h0) $display("FAIL reset_read_%0d: got rvalid=%b rdata=%h required 1 00000000", addrs[i], rvalid, rdata); else pass_cnt++;
      end
      @(negedge clk);
      total++; if (rvalid !== 1'b0) $display("FAIL rvalid_pulse: got %b required 0", rvalid); else pass_cnt++;
   endtask

   task automatic test_write_read();
      issue(1'b1, 7'd10, 4'hF, 32'h0000005A);
      issue(1'b0, 7'd10, 4'h0, 32'h0);
      total++; if (rvalid !== 1'b0 || rdata !== 32'h0) $display("FAIL write_no_rdata: got rvalid=%b rdata=%h required 0 00000000", rvalid, rdata); else pass_cnt++;
      @(negedge clk); req = 1'b0;
      total++; if (rvalid !== 1'b1 || rdata !== 32'h5A) $display("FAIL write_then_read: got rvalid=%b rdata=%h required 1 0000005a", rvalid, rdata); else pass_cnt++;
      issue(1'b1, 7'd10, 4'h0, 32'hFFFFFFFF);
      issue(1'b0, 7'd10, 4'h0, 32'h0);
      @(negedge clk); req = 1'b0;
      total++; if (rvalid !== 1'b1 || rdata !== 32'h5A) $display("FAIL be_zero_noop: got rvalid=%b rdata=%h required 1 0000005a", rvalid, rdata); else pass_cnt++;
   endtask

   task automatic test_byte_enable();
      issue(1'b1, 7'd5, 4'b1111, 32'hAABBCCDD);
      issue(1'b1, 7'd5, 4'b0101, 32'h11223344);
      issue(1'b0, 7'd5, 4'b0000, 32'h0);
      @(negedge clk); req = 1'b0;
      total++; if (rvalid !== 1'b1 || rdata !== 32'hAA22CC44) $display("FAIL byte_enable: got rvalid=%b rdata=%h required 1 aa22cc44", rvalid, rdata); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      issue(1'b1, 7'd20, 4'hF, 32'h00000100);
      issue(1'b1, 7'd21, 4'hF, 32'h00000200);
      issue(1'b0, 7'd20, 4'h0, 32'h0);
      @(negedge clk); addr = 7'd21;
      total++; if (rvalid !== 1'b1 || rdata !== 32'h100) $display("FAIL b2b_rd20: got rvalid=%b rdata=%h required 1 00000100", rvalid, rdata); else pass_cnt++;
      @(negedge clk); addr = 7'd5;
      total++; if (rvalid !== 1'b1 || rdata !== 32'h200) $display("FAIL b2b_rd21: got rvalid=%b rdata=%h required 1 00000200", rvalid, rdata); else pass_cnt++;
      @(negedge clk); addr = 7'd10;
      total++; if (rvalid !== 1'b1 || rdata !== 32'hAA22CC44) $display("FAIL b2b_rd5: got rvalid=%b rdata=%h required 1 aa22cc44", rvalid, rdata); else pass_cnt++;
      @(negedge clk); req = 1'b0;
      total++; if (rvalid !== 1'b1 || rdata !== 32'h5A) $display("FAIL b2b_rd10: got rvalid=%b rdata=%h required 1 0000005a", rvalid, rdata); else pass_cnt++;
      @(negedge clk);
      total++; if (rvalid !== 1'b0 || rdata !== 32'h5A) $display("FAIL rdata_hold: got rvalid=%b rdata=%h required 0 0000005a", rvalid, rdata); else pass_cnt++;
   endtask

   task automatic test_out_of_range();
      issue(1'b1, 7'd64, 4'hF, 32'h000000FF);
      issue(1'b0, 7'd64, 4'h0, 32'h0);
      total++; if (err !== 1'b1 || rvalid !== 1'b0 || rdata !== 32'h5A) $display("FAIL oor_write: got err=%b rvalid=%b rdata=%h required 1 0 0000005a", err, rvalid, rdata); else pass_cnt++;
      @(negedge clk); req = 1'b0;
      total++; if (err !== 1'b1 || rvalid !== 1'b0 || rdata !== 32'h5A) $display("FAIL oor_read: got err=%b rvalid=%b rdata=%h required 1 0 0000005a", err, rvalid, rdata); else pass_cnt++;
      @(negedge clk);
      total++; if (err !== 1'b0) $display("FAIL err_pulse: got %b required 0", err); else pass_cnt++;
      issue(1'b0, 7'd0, 4'h0, 32'h0);
      @(negedge clk); req = 1'b0;
      total++; if (rvalid !== 1'b1 || rdata !== 32'h0) $display("FAIL oor_no_alias: got rvalid=%b rdata=%h required 1 00000000", rvalid, rdata); else pass_cnt++;
   endtask

   task automatic test_clear_collision();
      int  cnt;
      logic seen;
      issue(1'b1, 7'd3, 4'hF, 32'h00000077);
      clr = 1'b1;
      @(posedge clk); #1;
      total++; if (busy !== 1'b1) $display("FAIL clr_enter: got busy=%b required 1", busy); else pass_cnt++;
      seen = rvalid | err;
      // keep requesting and clearing while busy: all of it must be ignored
      we = 1'b0; addr = 7'd5;
      cnt = 0;
      while (busy && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
         seen = seen | rvalid | err;
      end
      clr = 1'b0; req = 1'b0;
      total++; if (cnt !== 64) $display("FAIL clr_busy_len: got %0d required 64", cnt); else pass_cnt++;
      total++; if (seen !== 1'b0) $display("FAIL clr_ignores_req: got pulse=%b required 0", seen); else pass_cnt++;
      issue(1'b0, 7'd3, 4'h0, 32'h0);
      issue(1'b0, 7'd5, 4'h0, 32'h0);
      total++; if (rvalid !== 1'b1 || rdata !== 32'h0) $display("FAIL clr_addr3: got rvalid=%b rdata=%h required 1 00000000", rvalid, rdata); else pass_cnt++;
      @(negedge clk); req = 1'b0;
      total++; if (rvalid !== 1'b1 || rdata !== 32'h0) $display("FAIL clr_addr5: got rvalid=%b rdata=%h required 1 00000000", rvalid, rdata); else pass_cnt++;
   endtask

   task automatic test_mid_clear_reset();
      int cnt;
      issue(1'b1, 7'd7, 4'hF, 32'h00001234);
      issue(1'b0, 7'd7, 4'h0, 32'h0);
      @(negedge clk); req = 1'b0;
      total++; if (rvalid !== 1'b1 || rdata !== 32'h1234) $display("FAIL pre_clr_read: got rvalid=%b rdata=%h required 1 00001234", rvalid, rdata); else pass_cnt++;
      clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      repeat (19) @(negedge clk);
      total++; if (busy !== 1'b1) $display("FAIL mid_clr_busy: got %b required 1", busy); else pass_cnt++;
      reset = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b1 || rdata !== 32'h0 || rvalid !== 1'b0) $display("FAIL mid_clr_reset: got busy=%b rdata=%h rvalid=%b required 1 00000000 0", busy, rdata, rvalid); else pass_cnt++;
      reset = 1'b1;
      count_busy(cnt);
      total++; if (cnt !== 64) $display("FAIL mid_clr_restart_len: got %0d required 64", cnt); else pass_cnt++;
      issue(1'b0, 7'd7, 4'h0, 32'h0);
      @(negedge clk); req = 1'b0;
      total++; if (rvalid !== 1'b1 || rdata !== 32'h0) $display("FAIL mid_clr_zeroed: got rvalid=%b rdata=%h required 1 00000000", rvalid, rdata); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_enable();
      test_back_to_back();
      test_out_of_range();
      test_clear_collision();
      test_mid_clear_reset();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
